// File: rtl/demux18_tdm.sv
// Receive-side 1:8 demultiplexer: addressed writes to one channel, or TDM
// frames captured into a shadow bank and published to all channels at once.
module demux18_tdm #(
    parameter int width = 1
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             CSn,
    input  logic             Mode,
    input  logic             Valid,
    input  logic             Sync,
    input  logic [2:0]       Sw_In,
    input  logic [width-1:0] Din,
    output logic [width-1:0] Y0,
    output logic [width-1:0] Y1,
    output logic [width-1:0] Y2,
    output logic [width-1:0] Y3,
    output logic [width-1:0] Y4,
    output logic [width-1:0] Y5,
    output logic [width-1:0] Y6,
    output logic [width-1:0] Y7,
    output logic [2:0]       Slot,
    output logic             Busy,
    output logic             Frame_Done,
    output logic             Sync_Err
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       slot_q, slot_d;
    logic             busy_q, busy_d;
    logic             frameDone_q, frameDone_d;
    logic             syncErr_q, syncErr_d;
    logic [width-1:0] y_q [8];
    logic [width-1:0] y_d [8];
    logic [width-1:0] shadow_q [8];
    logic [width-1:0] shadow_d [8];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
            syncErr_q   <= 1'b0;
            y_q         <= '{default: '0};
            shadow_q    <= '{default: '0};
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            busy_q      <= busy_d;
            frameDone_q <= frameDone_d;
            syncErr_q   <= syncErr_d;
            y_q         <= y_d;
            shadow_q    <= shadow_d;
        end
    end

    // Flags default low so a deselected block clears them on the next edge.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        busy_d      = busy_q;
        frameDone_d = 1'b0;
        syncErr_d   = 1'b0;
        y_d         = y_q;
        shadow_d    = shadow_q;

        if (!CSn) begin
            if (!Mode) begin
                // Leaving TDM mode silently drops any partial frame.
                state_d = IDLE;
                slot_d  = '0;
                busy_d  = 1'b0;
                if (Valid) begin
                    y_d[Sw_In] = Din;
                end
            end else if (Valid) begin
                case (state_q)
                    IDLE: begin
                        if (Sync) begin
                            shadow_d[0] = Din;
                            slot_d      = 3'd1;
                            busy_d      = 1'b1;
                            state_d     = RECV;
                        end
                    end
                    RECV: begin
                        if (Sync) begin
                            syncErr_d   = 1'b1;
                            shadow_d[0] = Din;
                            slot_d      = 3'd1;
                        end else if (slot_q == 3'd7) begin
                            shadow_d[7] = Din;
                            for (int i = 0; i < 7; i++) begin
                                y_d[i] = shadow_q[i];
                            end
                            y_d[7]      = Din;
                            frameDone_d = 1'b1;
                            slot_d      = '0;
                            busy_d      = 1'b0;
                            state_d     = IDLE;
                        end else begin
                            shadow_d[slot_q] = Din;
                            slot_d           = slot_q + 3'd1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign Y0         = y_q[0];
    assign Y1         = y_q[1];
    assign Y2         = y_q[2];
    assign Y3         = y_q[3];
    assign Y4         = y_q[4];
    assign Y5         = y_q[5];
    assign Y6         = y_q[6];
    assign Y7         = y_q[7];
    assign Slot       = slot_q;
    assign Busy       = busy_q;
    assign Frame_Done = frameDone_q;
    assign Sync_Err   = syncErr_q;

endmodule

// File: tb/tb_demux18_tdm.sv
// Scoreboard bench for demux18_tdm: a behavioural model predicts every cycle,
// predictions are queued at drive time and compared one edge later.
module tb_demux18_tdm;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RSTn = 1'b0;
    logic         CSn = 1'b1;
    logic         Mode = 1'b0;
    logic         Valid = 1'b0;
    logic         Sync = 1'b0;
    logic [2:0]   Sw_In = 3'd0;
    logic [W-1:0] Din = '0;
    logic [W-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic [2:0]   slotOut;
    logic         busyOut, frameDoneOut, syncErrOut;
    logic [7:0][W-1:0] dutY;

    assign dutY = {y7, y6, y5, y4, y3, y2, y1, y0};

    demux18_tdm #(.width(W)) dut (
        .CLK(CLK), .RSTn(RSTn), .CSn(CSn), .Mode(Mode), .Valid(Valid),
        .Sync(Sync), .Sw_In(Sw_In), .Din(Din),
        .Y0(y0), .Y1(y1), .Y2(y2), .Y3(y3), .Y4(y4), .Y5(y5), .Y6(y6), .Y7(y7),
        .Slot(slotOut), .Busy(busyOut), .Frame_Done(frameDoneOut),
        .Sync_Err(syncErrOut)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0][W-1:0] y;
        logic [2:0]        slot;
        logic              busy;
        logic              fd;
        logic              se;
    } expect_t;

    expect_t sbQueue[$];
    int nCompared = 0;
    int nMismatched = 0;
    int seSeen = 0;
    int fdSeen = 0;

    // Reference model state
    logic [7:0][W-1:0] mY, mShadow;
    logic [2:0]        mSlot;
    logic              mBusy, mFd, mSe;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mY = '0; mShadow = '0; mSlot = '0; mBusy = 1'b0; mFd = 1'b0; mSe = 1'b0;
    endtask

    task automatic modelStep(input logic csn, input logic mode, input logic valid,
                             input logic sync, input logic [2:0] sw, input logic [W-1:0] din);
        logic fd, se;
        fd = 1'b0;
        se = 1'b0;
        if (!csn) begin
            if (!mode) begin
                mBusy = 1'b0;
                mSlot = '0;
                if (valid) mY[sw] = din;
            end else if (valid) begin
                if (!mBusy) begin
                    if (sync) begin
                        mShadow[0] = din; mSlot = 3'd1; mBusy = 1'b1;
                    end
                end else if (sync) begin
                    se = 1'b1; mShadow[0] = din; mSlot = 3'd1;
                end else if (mSlot == 3'd7) begin
                    mShadow[7] = din;
                    mY = mShadow;
                    fd = 1'b1; mSlot = '0; mBusy = 1'b0;
                end else begin
                    mShadow[mSlot] = din;
                    mSlot = mSlot + 3'd1;
                end
            end
        end
        mFd = fd;
        mSe = se;
    endtask

    task automatic pushExpect();
        expect_t e;
        e.y = mY; e.slot = mSlot; e.busy = mBusy; e.fd = mFd; e.se = mSe;
        sbQueue.push_back(e);
    endtask

    task automatic compareFront();
        expect_t e;
        if (sbQueue.size() == 0) begin
            checkOutput("sbEmpty", 32'd1, 32'd0);
            return;
        end
        e = sbQueue.pop_front();
        for (int i = 0; i < 8; i++) checkOutput($sformatf("Y%0d", i), 32'(dutY[i]), 32'(e.y[i]));
        checkOutput("Slot", 32'(slotOut), 32'(e.slot));
        checkOutput("Busy", 32'(busyOut), 32'(e.busy));
        checkOutput("Frame_Done", 32'(frameDoneOut), 32'(e.fd));
        checkOutput("Sync_Err", 32'(syncErrOut), 32'(e.se));
        if (frameDoneOut === 1'b1) fdSeen++;
        if (syncErrOut === 1'b1) seSeen++;
    endtask

    task automatic applyStimulus(input logic csn, input logic mode, input logic valid,
                                 input logic sync, input logic [2:0] sw, input logic [W-1:0] din);
        CSn = csn; Mode = mode; Valid = valid; Sync = sync; Sw_In = sw; Din = din;
        modelStep(csn, mode, valid, sync, sw, din);
        pushExpect();
        @(posedge CLK);
        #1;
        compareFront();
    endtask

    // Asynchronous reset, asserted and released between clock edges.
    task automatic resetDut();
        RSTn = 1'b0;
        #2;
        modelReset();
        sbQueue.delete();
        pushExpect();
        compareFront();
        RSTn = 1'b1;
        CSn = 1'b0; Valid = 1'b0; Sync = 1'b0;
    endtask

    task automatic sendFrame(input logic [W-1:0] first);
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b1, 1'b1, k == 0, 3'd0, W'(first + k));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        resetDut();

        // Addressed writes; Sync is ignored in this mode.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 4'hA);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'h3);
        checkOutput("addrY5", 32'(y5), 32'hA);
        checkOutput("addrY0", 32'(y0), 32'h3);
        checkOutput("addrY3", 32'(y3), 32'h0);

        // Clean TDM frame 1..8.
        resetDut();
        sendFrame(4'd1);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("frameY%0d", i), 32'(dutY[i]), 32'(i + 1));
        checkOutput("fdCount1", 32'(fdSeen), 32'd1);

        // CSn high right after a published frame clears Frame_Done only.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 4'hF);

        // Stall and chip-select freeze in the middle of a frame.
        resetDut();
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b1, k == 0, 3'd0, W'(k + 1));
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'hE);
        checkOutput("stallSlot", 32'(slotOut), 32'd4);
        for (int k = 4; k < 6; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, W'(k + 1));
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 4'hD);
        checkOutput("freezeSlot", 32'(slotOut), 32'd6);
        for (int k = 6; k < 8; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, W'(k + 1));
        for (int i = 0; i < 8; i++) checkOutput($sformatf("stallY%0d", i), 32'(dutY[i]), 32'(i + 1));

        // Sync arriving mid-frame restarts the frame.
        resetDut();
        seSeen = 0;
        fdSeen = 0;
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b1, k == 0, 3'd0, W'(k + 1));
        sendFrame(4'd9);
        checkOutput("seCount", 32'(seSeen), 32'd1);
        checkOutput("fdCount2", 32'(fdSeen), 32'd1);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("syncY%0d", i), 32'(dutY[i]), 32'((9 + i) & 15));

        // Abort by switching to addressed mode.
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b1, k == 0, 3'd0, 4'd7);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        checkOutput("modeAbortBusy", 32'(busyOut), 32'd0);

        // Abort by asynchronous reset mid-frame.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 4'd7);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd7);
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);

        // Unsynchronised words from IDLE are discarded.
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'h6);
        checkOutput("garbageSlot", 32'(slotOut), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
